// File: rtl/weak_signal_generator.sv
// Two-channel DDS test source: attenuated (optionally noisy) sine plus reference.
// Optional LFSR noise path is compiled in with `define WSG_NOISE_EN.
module weak_signal_generator #(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   start,
    input  logic [PHASE_WIDTH-1:0] tuning_word,
    input  logic [15:0]            phase_offset,
    input  logic [DIV_WIDTH-1:0]   sample_div,
    input  logic [3:0]             amp_shift,
    input  logic                   noise_en,
    input  logic [3:0]             noise_shift,
    input  logic [15:0]            burst_len,
    output logic [DATA_WIDTH-1:0]  ch1_data,
    output logic [DATA_WIDTH-1:0]  ch2_data,
    output logic                   data_valid,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [PHASE_WIDTH-1:0]  phase_q;
    logic [DIV_WIDTH-1:0]    div_q;
    logic [15:0]             cnt_q;
    logic [15:0]             burst_q;
    logic                    v1_q;
    logic signed [15:0]      s1_q;
    logic signed [15:0]      s2_q;
    logic signed [15:0]      n1_q;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   ch1_q;
    logic [DATA_WIDTH-1:0]   ch2_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    tick;
    logic                    last;
    logic [15:0]             ph_top;
    logic signed [15:0]      sin1;
    logic signed [15:0]      sin2;
    logic signed [15:0]      noise_d;
    logic signed [15:0]      att;
    logic signed [16:0]      sum17;
    logic signed [15:0]      ch1_sat;

    // Parabolic sine: u*(32768-u)/8192 peaks at exactly 32768, hence the clamp.
    function automatic logic signed [15:0] sine16(input logic [15:0] q);
        logic [30:0] prod;
        logic [30:0] sh;
        logic [14:0] m;
        prod = {16'd0, q[14:0]} * (31'd32768 - {16'd0, q[14:0]});
        sh   = prod >> 13;
        m    = (sh > 31'd32767) ? 15'h7fff : sh[14:0];
        return q[15] ? -$signed({1'b0, m}) : $signed({1'b0, m});
    endfunction

`ifdef WSG_NOISE_EN
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2345;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    logic [31:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (state_q == S_IDLE && start && enable) begin
            lfsr_q <= LFSR_SEED;
        end else if (tick) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
        end
    end

    assign noise_d = noise_en ? ($signed(lfsr_q[15:0]) >>> noise_shift)
                              : 16'sd0;
`else
    logic unused_noise;
    assign unused_noise = ^{noise_en, noise_shift};
    assign noise_d      = 16'sd0;
`endif

    always_comb begin
        tick    = (state_q == S_RUN) && (div_q == sample_div);
        last    = valid_q && (burst_q != 16'd0)
                  && ((cnt_q + 16'd1) == burst_q);
        ph_top  = phase_q[PHASE_WIDTH-1 -: 16];
        sin1    = sine16(ph_top);
        sin2    = sine16(ph_top + phase_offset);
        att     = s1_q >>> amp_shift;
        sum17   = {att[15], att} + {n1_q[15], n1_q};
        ch1_sat = sum17[15:0];
        if (sum17[16] != sum17[15]) begin
            ch1_sat = sum17[16] ? 16'sh8000 : 16'sh7fff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            v1_q    <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            n1_q    <= '0;
            valid_q <= 1'b0;
            ch1_q   <= '0;
            ch2_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    v1_q    <= 1'b0;
                    valid_q <= 1'b0;
                    if (start && enable) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        burst_q <= burst_len;
                        phase_q <= '0;
                        div_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        v1_q    <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (last) begin
                        // Flush ticks already in flight past the final sample.
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        v1_q    <= 1'b0;
                        valid_q <= 1'b0;
                        cnt_q   <= cnt_q + 16'd1;
                    end else begin
                        div_q <= tick ? '0 : div_q + DIV_WIDTH'(1);
                        v1_q  <= tick;
                        if (tick) begin
                            phase_q <= phase_q + tuning_word;
                            s1_q    <= sin1;
                            s2_q    <= sin2;
                            n1_q    <= noise_d;
                        end
                        valid_q <= v1_q;
                        if (v1_q) begin
                            ch1_q <= ch1_sat;
                            ch2_q <= s2_q;
                        end
                        if (valid_q) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ch1_data   = ch1_q;
    assign ch2_data   = ch2_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_weak_signal_generator.sv
// Randomized self-checking bench for weak_signal_generator.
// Define WSG_NOISE_EN to also exercise the noise path.
module tb_weak_signal_generator;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic [31:0] tuning_word;
    logic [15:0] phase_offset;
    logic [15:0] sample_div;
    logic [3:0]  amp_shift;
    logic        noise_en;
    logic [3:0]  noise_shift;
    logic [15:0] burst_len;
    logic [15:0] ch1_data;
    logic [15:0] ch2_data;
    logic        data_valid;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    int   sc[$];
    int   d1[$];
    int   d2[$];
    int   donec[$];
    logic busy_end;

    weak_signal_generator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .start        (start),
        .tuning_word  (tuning_word),
        .phase_offset (phase_offset),
        .sample_div   (sample_div),
        .amp_shift    (amp_shift),
        .noise_en     (noise_en),
        .noise_shift  (noise_shift),
        .burst_len    (burst_len),
        .ch1_data     (ch1_data),
        .ch2_data     (ch2_data),
        .data_valid   (data_valid),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int sin_ref(input logic [15:0] q);
        int u;
        int m;
        u = int'(q & 16'h7fff);
        m = (u * (32768 - u)) / 8192;
        if (m > 32767) m = 32767;
        return q[15] ? -m : m;
    endfunction

    function automatic logic [31:0] phase_of(input int n, input logic [31:0] tw);
        logic [31:0] nn;
        nn = n;
        return nn * tw;
    endfunction

    function automatic int exp_ch1(input int n, input logic [31:0] tw,
                                   input int amp, input bit nen, input int nsh);
        logic [31:0] p;
        logic [31:0] lf;
        int s;
        int nz;
        p  = phase_of(n, tw);
        s  = sin_ref(p[31:16]) >>> amp;
        nz = 0;
        lf = 32'hACE1_2345;
`ifdef WSG_NOISE_EN
        if (nen) begin
            for (int i = 0; i < n; i++)
                lf = (lf >> 1) ^ (lf[0] ? 32'h8020_0003 : 32'd0);
            nz = int'($signed(lf[15:0])) >>> nsh;
        end
`endif
        s = s + nz;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    function automatic int exp_ch2(input int n, input logic [31:0] tw,
                                   input logic [15:0] off);
        logic [31:0] p;
        logic [15:0] a;
        p = phase_of(n, tw);
        a = p[31:16] + off;
        return sin_ref(a);
    endfunction

    task automatic set_cfg(input logic [31:0] tw, input logic [15:0] off,
                           input logic [15:0] dv, input logic [3:0] amp,
                           input logic nen, input logic [3:0] nsh,
                           input logic [15:0] bl);
        tuning_word  = tw;
        phase_offset = off;
        sample_div   = dv;
        amp_shift    = amp;
        noise_en     = nen;
        noise_shift  = nsh;
        burst_len    = bl;
    endtask

    task automatic capture(input int maxcyc);
        sc.delete();
        d1.delete();
        d2.delete();
        donec.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= maxcyc; k++) begin
            if (data_valid) begin
                sc.push_back(k);
                d1.push_back(int'($signed(ch1_data)));
                d2.push_back(int'($signed(ch2_data)));
            end
            if (done) donec.push_back(k);
            busy_end = busy;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        start = 1'b0;
        set_cfg(32'd0, 16'd0, 16'd0, 4'd0, 1'b0, 4'd0, 16'd0);
        repeat (3) @(negedge clk);
        tests++;
        if ({ch1_data, ch2_data, data_valid, busy, done} !== 35'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {ch1_data, ch2_data, data_valid, busy, done});
        end
        rst_n = 1'b1;
        set_cfg(32'h4000_0000, 16'd0, 16'd0, 4'd0, 1'b0, 4'd0, 16'd8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL start_no_enable: got busy=%b dv=%b expected 0 0",
                     busy, data_valid);
        end
    endtask

    task automatic test_basic();
        int pat[4];
        pat = '{0, 32767, 0, -32767};
        enable = 1'b1;
        set_cfg(32'h4000_0000, 16'd0, 16'd0, 4'd0, 1'b0, 4'd0, 16'd8);
        capture(16);
        tests++;
        if (sc.size() != 8) begin
            fails++;
            $display("FAIL basic_count: got %0d expected 8", sc.size());
        end
        for (int i = 0; i < sc.size() && i < 8; i++) begin
            tests++;
            if (sc[i] != i + 3 || d1[i] != pat[i % 4] || d2[i] != pat[i % 4]) begin
                fails++;
                $display("FAIL basic_sample%0d: got cyc=%0d ch1=%0d ch2=%0d expected cyc=%0d val=%0d",
                         i, sc[i], d1[i], d2[i], i + 3, pat[i % 4]);
            end
        end
        tests++;
        if (donec.size() != 1 || (donec.size() == 1 && donec[0] != 11)) begin
            fails++;
            $display("FAIL basic_done: got %0d pulses expected 1 at cycle 11",
                     donec.size());
        end
        tests++;
        if (busy_end !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy_end: got %b expected 0", busy_end);
        end
    endtask

    task automatic test_offset();
        int p1[4];
        int p2[4];
        p1 = '{0, 32767, 0, -32767};
        p2 = '{32767, 0, -32767, 0};
        set_cfg(32'h4000_0000, 16'h4000, 16'd0, 4'd0, 1'b0, 4'd0, 16'd8);
        capture(16);
        tests++;
        if (sc.size() != 8) begin
            fails++;
            $display("FAIL offset_count: got %0d expected 8", sc.size());
        end
        for (int i = 0; i < sc.size() && i < 8; i++) begin
            tests++;
            if (d1[i] != p1[i % 4] || d2[i] != p2[i % 4]) begin
                fails++;
                $display("FAIL offset_sample%0d: got ch1=%0d ch2=%0d expected %0d %0d",
                         i, d1[i], d2[i], p1[i % 4], p2[i % 4]);
            end
        end
    endtask

    task automatic test_amp();
        int pat[4];
        pat = '{0, 2047, 0, -2048};
        set_cfg(32'h4000_0000, 16'd0, 16'd0, 4'd4, 1'b0, 4'd0, 16'd8);
        capture(16);
        tests++;
        if (sc.size() != 8) begin
            fails++;
            $display("FAIL amp_count: got %0d expected 8", sc.size());
        end
        for (int i = 0; i < sc.size() && i < 8; i++) begin
            tests++;
            if (d1[i] != pat[i % 4]) begin
                fails++;
                $display("FAIL amp_sample%0d: got %0d expected %0d", i, d1[i], pat[i % 4]);
            end
        end
    endtask

    task automatic test_div();
        set_cfg(32'h4000_0000, 16'd0, 16'd9, 4'd0, 1'b0, 4'd0, 16'd5);
        capture(70);
        tests++;
        if (sc.size() != 5 || (sc.size() == 5 && sc[0] != 12)) begin
            fails++;
            $display("FAIL div_first: got %0d strobes expected 5 first at 12", sc.size());
        end
        for (int i = 1; i < sc.size(); i++) begin
            tests++;
            if (sc[i] - sc[i-1] != 10) begin
                fails++;
                $display("FAIL div_spacing%0d: got %0d expected 10", i, sc[i] - sc[i-1]);
            end
        end
        tests++;
        if (donec.size() != 1 || (sc.size() > 0 && donec.size() == 1
                                  && donec[0] != sc[sc.size()-1] + 1)) begin
            fails++;
            $display("FAIL div_done: got %0d pulses expected 1 after last strobe",
                     donec.size());
        end
    endtask

    task automatic test_continuous();
        logic [31:0] tw;
        int bad;
        tw = $urandom;
        set_cfg(tw, 16'h1234, 16'd0, 4'd1, 1'b0, 4'd0, 16'd0);
        capture(1100);
        tests++;
        if (sc.size() != 1098 || donec.size() != 0 || busy_end !== 1'b1) begin
            fails++;
            $display("FAIL cont_run: got strobes=%0d done=%0d busy=%b expected 1098 0 1",
                     sc.size(), donec.size(), busy_end);
        end
        bad = 0;
        for (int i = 0; i < sc.size(); i++) begin
            if (sc[i] != i + 3 || d1[i] != exp_ch1(i, tw, 1, 1'b0, 0)
                || d2[i] != exp_ch2(i, tw, 16'h1234))
                bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL cont_values: got %0d bad samples expected 0", bad);
        end
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_abort();
        logic [31:0] tw;
        int seen;
        int extra;
        int dn;
        tw = $urandom;
        set_cfg(tw, 16'd0, 16'd0, 4'd0, 1'b0, 4'd0, 16'd8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 30 && seen < 3; k++) begin
            if (data_valid) seen++;
            if (seen < 3) @(negedge clk);
        end
        tests++;
        if (seen != 3) begin
            fails++;
            $display("FAIL abort_reach3: got %0d strobes expected 3", seen);
        end
        enable = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_stop: got busy=%b dv=%b expected 0 0", busy, data_valid);
        end
        extra = 0;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            if (data_valid) extra++;
            if (done) dn++;
            @(negedge clk);
        end
        tests++;
        if (extra != 0 || dn != 0) begin
            fails++;
            $display("FAIL abort_quiet: got strobes=%0d done=%0d expected 0 0", extra, dn);
        end
        enable = 1'b1;
        capture(16);
        tests++;
        if (sc.size() != 8 || donec.size() != 1) begin
            fails++;
            $display("FAIL abort_replay_count: got %0d/%0d expected 8/1",
                     sc.size(), donec.size());
        end
        for (int i = 0; i < sc.size(); i++) begin
            tests++;
            if (d1[i] != exp_ch1(i, tw, 0, 1'b0, 0)) begin
                fails++;
                $display("FAIL abort_replay%0d: got %0d expected %0d",
                         i, d1[i], exp_ch1(i, tw, 0, 1'b0, 0));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] tw;
        logic [15:0] off;
        int dv;
        int amp;
        int nsh;
        int bl;
        bit nen;
        for (int it = 0; it < 8; it++) begin
            tw  = $urandom;
            off = 16'($urandom);
            dv  = $urandom_range(0, 3);
            amp = $urandom_range(0, 15);
            nsh = $urandom_range(0, 15);
            nen = 1'($urandom_range(0, 1));
            bl  = $urandom_range(1, 10);
            set_cfg(tw, off, 16'(dv), 4'(amp), nen, 4'(nsh), 16'(bl));
            capture((dv + 1) * bl + 6);
            tests++;
            if (sc.size() != bl || donec.size() != 1 || busy_end !== 1'b0) begin
                fails++;
                $display("FAIL rand%0d_count: got %0d/%0d/%b expected %0d/1/0",
                         it, sc.size(), donec.size(), busy_end, bl);
            end
            for (int i = 0; i < sc.size(); i++) begin
                tests++;
                if (sc[i] != dv + 3 + i * (dv + 1)
                    || d1[i] != exp_ch1(i, tw, amp, nen, nsh)
                    || d2[i] != exp_ch2(i, tw, off)) begin
                    fails++;
                    $display("FAIL rand%0d_s%0d: got cyc=%0d ch1=%0d ch2=%0d expected %0d %0d %0d",
                             it, i, sc[i], d1[i], d2[i], dv + 3 + i * (dv + 1),
                             exp_ch1(i, tw, amp, nen, nsh), exp_ch2(i, tw, off));
                end
            end
        end
    endtask

`ifdef WSG_NOISE_EN
    task automatic test_noise();
        int saved[$];
        int distinct;
        set_cfg(32'h4000_0000, 16'd0, 16'd0, 4'd0, 1'b1, 4'd0, 16'd16);
        capture(24);
        tests++;
        if (sc.size() != 16) begin
            fails++;
            $display("FAIL noise_count: got %0d expected 16", sc.size());
        end
        distinct = 0;
        for (int i = 0; i < sc.size(); i++) begin
            tests++;
            if (d1[i] != exp_ch1(i, 32'h4000_0000, 0, 1'b1, 0)) begin
                fails++;
                $display("FAIL noise_s%0d: got %0d expected %0d",
                         i, d1[i], exp_ch1(i, 32'h4000_0000, 0, 1'b1, 0));
            end
            if (i > 0 && d1[i] != d1[0]) distinct++;
        end
        tests++;
        if (distinct == 0) begin
            fails++;
            $display("FAIL noise_stuck: got %0d changes expected >0", distinct);
        end
        saved = d1;
        capture(24);
        tests++;
        if (d1 != saved) begin
            fails++;
            $display("FAIL noise_replay: got %0d samples differing expected identical",
                     d1.size());
        end
    endtask
`endif

    task automatic test_reset_mid();
        set_cfg(32'h1357_9bdf, 16'h0100, 16'd0, 4'd0, 1'b0, 4'd0, 16'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre: got busy=%b dv=%b expected 1 1", busy, data_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ch1_data, ch2_data, data_valid, busy, done} !== 35'd0) begin
            fails++;
            $display("FAIL midrst_clear: got %h expected 0",
                     {ch1_data, ch2_data, data_valid, busy, done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_idle: got busy=%b dv=%b expected 0 0", busy, data_valid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_offset();
        test_amp();
        test_div();
        test_continuous();
        test_abort();
        test_random();
`ifdef WSG_NOISE_EN
        test_noise();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
